mio_bus_seq: RTL and testbench

//  Registered, multi-slot memory/IO bus between the CPU data port and data RAM + N_IO peripherals.

---
 rtl/mio_bus_seq.sv | 183 ++++++++++++++++++
 tb/tb_mio_bus_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_seq.sv
// Registered CPU data-port bus: decodes each request to data RAM, an IO slot or the
// internal error-count status slot, with RAM wait states, IO ready handshake and IO timeout.
module mio_bus_seq #(
  parameter int unsigned N_IO     = 4,
  parameter logic [31:0] IO_BASE  = 32'hFFFF0000,
  parameter int unsigned RAM_AW   = 7,
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [2:0]             cpu_amp,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_err,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [31:0]            ram_wdata,
  output logic                   ram_we,
  output logic [2:0]             ram_amp,
  input  logic [31:0]            ram_rdata,
  output logic [N_IO-1:0]        io_sel,
  output logic                   io_we,
  output logic [31:0]            io_wdata,
  input  logic [32*N_IO-1:0]     io_rdata,
  input  logic [N_IO-1:0]        io_ready
);

  typedef enum logic [1:0] {IDLE, DRAM, DIO, RESP} state_e;

  state_e            state_q;
  logic [3:0]        wait_q;
  logic [7:0]        tmo_q;
  logic              we_q;
  logic              unmapped_q;
  logic [15:0]       err_cnt_q;
  logic [31:0]       rdata_q;
  logic [31:0]       wdata_q;
  logic              ack_q;
  logic              err_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [2:0]        amp_q;
  logic [N_IO-1:0]   io_sel_q;
  logic              io_we_q;

  logic              is_io;
  logic [5:0]        slot;
  logic              slot_ext;
  logic [N_IO-1:0]   sel_d;
  logic              io_hit;
  logic [31:0]       io_rd;
  logic [15:0]       err_inc;
  logic              unused_addr;

  assign is_io       = (cpu_addr[31:8] == IO_BASE[31:8]);
  assign slot        = cpu_addr[7:2];
  assign slot_ext    = (slot != 6'd0) && (32'(slot) <= N_IO);
  assign err_inc     = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  assign unused_addr = ^cpu_addr[1:0];

  // Slot s maps to external select bit s-1; only the selected slot's ready/data matter.
  always_comb begin
    sel_d  = '0;
    io_hit = 1'b0;
    io_rd  = '0;
    for (int k = 0; k < int'(N_IO); k++) begin
      sel_d[k] = (slot == 6'(k + 1));
      if (io_sel_q[k]) begin
        io_hit = io_ready[k];
        io_rd  = io_rdata[32*k +: 32];
      end
    end
  end

  // Status and unmapped accesses spend one silent RESP cycle (ack_q still 0) before acking,
  // so every path leaves RESP the cycle after its ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      unmapped_q <= 1'b0;
      err_cnt_q  <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      amp_q      <= '0;
      io_sel_q   <= '0;
      io_we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            if (!is_io) begin
              ram_addr_q <= cpu_addr[RAM_AW+1:2];
              amp_q      <= cpu_amp;
              ram_we_q   <= cpu_we;
              wait_q     <= 4'(RAM_WAIT);
              state_q    <= DRAM;
            end else if (slot_ext) begin
              io_sel_q <= sel_d;
              io_we_q  <= cpu_we;
              tmo_q    <= '0;
              state_q  <= DIO;
            end else begin
              unmapped_q <= (slot != 6'd0);
              state_q    <= RESP;
            end
          end
        end
        DRAM: begin
          ram_we_q <= 1'b0;
          if (wait_q == 4'd0) begin
            if (!we_q) rdata_q <= ram_rdata;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        DIO: begin
          io_we_q <= 1'b0;
          if (io_hit) begin
            if (!we_q) rdata_q <= io_rd;
            ack_q    <= 1'b1;
            io_sel_q <= '0;
            state_q  <= RESP;
          end else if (tmo_q == 8'(TIMEOUT - 1)) begin
            rdata_q   <= '0;
            ack_q     <= 1'b1;
            err_q     <= 1'b1;
            err_cnt_q <= err_inc;
            io_sel_q  <= '0;
            state_q   <= RESP;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        RESP: begin
          if (ack_q) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            ack_q <= 1'b1;
            if (unmapped_q) begin
              rdata_q   <= '0;
              err_q     <= 1'b1;
              err_cnt_q <= err_inc;
            end else if (we_q) begin
              err_cnt_q <= '0;
            end else begin
              rdata_q <= {16'h0000, err_cnt_q};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_amp   = amp_q;
  assign io_sel    = io_sel_q;
  assign io_we     = io_we_q;
  assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mio_bus_seq.sv
// Directed bench for mio_bus_seq: a table of single accesses with expected latency/data/error,
// followed by hand sequences for reset mid-access and a request held across busy cycles.
module tb_mio_bus_seq;

  localparam int N_IO = 4;
  localparam logic [31:0] IO0 = 32'h1111AAAA;
  localparam logic [31:0] IO1 = 32'h2222BBBB;
  localparam logic [31:0] IO2 = 32'h3333CCCC;
  localparam logic [31:0] IO3 = 32'h4444DDDD;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [2:0]        cpu_amp = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic [6:0]        ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [2:0]        ram_amp;
  logic [31:0]       ram_rdata;
  logic [N_IO-1:0]   io_sel;
  logic              io_we;
  logic [31:0]       io_wdata;
  logic [32*N_IO-1:0] io_rdata;
  logic [N_IO-1:0]   io_ready = '0;

  logic [31:0] mem [128];

  int errors = 0;
  int checks = 0;

  int          obsLat;
  logic [31:0] obsRd;
  logic        obsErr;
  int          obsRamWe;
  int          obsIoWe;
  int          obsSelBad;
  logic        obsRamWe1;
  logic [6:0]  obsRamAddr1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          readyAt;
    logic [3:0]  readyMask;
    int          expLat;
    logic [31:0] expRd;
    logic        expErr;
    logic [3:0]  expSel;
    int          expRamWe;
    int          expIoWe;
    int          expRamAddr;
  } vec_t;

  vec_t vecs[18];

  mio_bus_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_amp   (cpu_amp),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_amp   (ram_amp),
    .ram_rdata (ram_rdata),
    .io_sel    (io_sel),
    .io_we     (io_we),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ready  (io_ready)
  );

  always #5 clk = ~clk;

  assign io_rdata  = {IO3, IO2, IO1, IO0};
  assign ram_rdata = mem[ram_addr];

  // Simple synchronous-write RAM standing in for the data memory.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One request, held until its ack; readyAt is the cycle after acceptance that pulses io_ready.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input int readyAt, input logic [3:0] readyMask,
                               input logic [3:0] expSel);
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_amp   = 3'b010;
    io_ready  = '0;
    obsLat = -1; obsRd = '0; obsErr = 1'b0; obsRamWe = 0; obsIoWe = 0; obsSelBad = 0;
    obsRamWe1 = 1'b0; obsRamAddr1 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      io_ready = (n == readyAt) ? readyMask : 4'b0000;
      if (n == 1) begin
        obsRamWe1   = ram_we;
        obsRamAddr1 = ram_addr;
      end
      if (ram_we) obsRamWe++;
      if (io_we) obsIoWe++;
      if (cpu_ack) begin
        if (io_sel !== 4'b0000) obsSelBad++;
        obsLat = n;
        obsRd  = cpu_rdata;
        obsErr = cpu_err;
        break;
      end else if (io_sel !== expSel) begin
        obsSelBad++;
      end
    end
    cpu_req  = 1'b0;
    io_ready = '0;
  endtask

  initial begin
    int ackCnt;
    logic [31:0] ackMask;

    for (int i = 0; i < 128; i++) mem[i] = '0;

    //         we    addr          wdata         rdy mask    lat rd            err sel     rWe iWe rAddr
    vecs[0]  = '{1'b1, 32'h00000010, 32'hDEADBEEF, -1, 4'b0000, 3,  32'h00000000, 1'b0, 4'b0000, 1, 0, 4};
    vecs[1]  = '{1'b0, 32'h00000010, 32'h0,        -1, 4'b0000, 3,  32'hDEADBEEF, 1'b0, 4'b0000, 0, 0, 4};
    vecs[2]  = '{1'b1, 32'h00000014, 32'h12345678, -1, 4'b0000, 3,  32'hDEADBEEF, 1'b0, 4'b0000, 1, 0, 5};
    vecs[3]  = '{1'b0, 32'h00000014, 32'h0,        -1, 4'b0000, 3,  32'h12345678, 1'b0, 4'b0000, 0, 0, 5};
    vecs[4]  = '{1'b0, 32'h00000210, 32'h0,        -1, 4'b0000, 3,  32'hDEADBEEF, 1'b0, 4'b0000, 0, 0, 4};
    vecs[5]  = '{1'b0, 32'hFFFF0214, 32'h0,        -1, 4'b0000, 3,  32'h12345678, 1'b0, 4'b0000, 0, 0, 5};
    vecs[6]  = '{1'b0, 32'hFFFF0004, 32'h0,         4, 4'b0001, 5,  IO0,          1'b0, 4'b0001, 0, 0, -1};
    vecs[7]  = '{1'b0, 32'hFFFF0010, 32'h0,         1, 4'b1000, 2,  IO3,          1'b0, 4'b1000, 0, 0, -1};
    vecs[8]  = '{1'b1, 32'hFFFF0008, 32'h55AA55AA,  2, 4'b0010, 3,  IO3,          1'b0, 4'b0010, 0, 1, -1};
    vecs[9]  = '{1'b0, 32'hFFFF0008, 32'h0,        -1, 4'b0000, 16, 32'h00000000, 1'b1, 4'b0010, 0, 0, -1};
    vecs[10] = '{1'b0, 32'hFFFF0000, 32'h0,        -1, 4'b0000, 2,  32'h00000001, 1'b0, 4'b0000, 0, 0, -1};
    vecs[11] = '{1'b0, 32'hFFFF0040, 32'h0,        -1, 4'b0000, 2,  32'h00000000, 1'b1, 4'b0000, 0, 0, -1};
    vecs[12] = '{1'b0, 32'hFFFF0000, 32'h0,        -1, 4'b0000, 2,  32'h00000002, 1'b0, 4'b0000, 0, 0, -1};
    vecs[13] = '{1'b1, 32'hFFFF0000, 32'hFFFFFFFF, -1, 4'b0000, 2,  32'h00000002, 1'b0, 4'b0000, 0, 0, -1};
    vecs[14] = '{1'b0, 32'hFFFF0000, 32'h0,        -1, 4'b0000, 2,  32'h00000000, 1'b0, 4'b0000, 0, 0, -1};
    vecs[15] = '{1'b0, 32'hFFFF000C, 32'h0,         3, 4'b0001, 16, 32'h00000000, 1'b1, 4'b0100, 0, 0, -1};
    vecs[16] = '{1'b0, 32'hFFFF0004, 32'h0,        15, 4'b0001, 16, IO0,          1'b0, 4'b0001, 0, 0, -1};
    vecs[17] = '{1'b0, 32'hFFFF0000, 32'h0,        -1, 4'b0000, 2,  32'h00000001, 1'b0, 4'b0000, 0, 0, -1};

    #12;
    checkOutput("reset ack/err/we", {28'h0, cpu_ack, cpu_err, ram_we, io_we}, 32'h0);
    checkOutput("reset rdata", cpu_rdata, 32'h0);
    checkOutput("reset io_sel", {28'h0, io_sel}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].readyAt,
                    vecs[i].readyMask, vecs[i].expSel);
      checkOutput($sformatf("row%0d latency", i), obsLat, vecs[i].expLat);
      checkOutput($sformatf("row%0d rdata", i), obsRd, vecs[i].expRd);
      checkOutput($sformatf("row%0d err", i), {31'h0, obsErr}, {31'h0, vecs[i].expErr});
      checkOutput($sformatf("row%0d io_sel bad cycles", i), obsSelBad, 0);
      checkOutput($sformatf("row%0d ram_we cycles", i), obsRamWe, vecs[i].expRamWe);
      checkOutput($sformatf("row%0d ram_we first cycle", i), {31'h0, obsRamWe1},
                  (vecs[i].expRamWe > 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("row%0d io_we cycles", i), obsIoWe, vecs[i].expIoWe);
      if (vecs[i].expRamAddr >= 0)
        checkOutput($sformatf("row%0d ram_addr", i), {25'h0, obsRamAddr1}, vecs[i].expRamAddr);
    end

    // Reset asserted while a RAM read sits in its wait cycle.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00000010; cpu_wdata = 32'hCAFE0000; cpu_amp = 3'b101;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    checkOutput("abort ram_addr before reset", {25'h0, ram_addr}, 32'h4);
    checkOutput("abort ram_amp before reset", {29'h0, ram_amp}, 32'h5);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checkOutput("abort ack/err/we", {28'h0, cpu_ack, cpu_err, ram_we, io_we}, 32'h0);
    checkOutput("abort rdata", cpu_rdata, 32'h0);
    checkOutput("abort ram_addr", {25'h0, ram_addr}, 32'h0);
    checkOutput("abort ram_amp", {29'h0, ram_amp}, 32'h0);
    checkOutput("abort ram_wdata", ram_wdata, 32'h0);
    checkOutput("abort io_wdata", io_wdata, 32'h0);
    checkOutput("abort io_sel", {28'h0, io_sel}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    ackCnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (cpu_ack) ackCnt++;
    end
    checkOutput("abort no ack", ackCnt, 0);
    applyStimulus(1'b0, 32'hFFFF0000, 32'h0, -1, 4'b0000, 4'b0000);
    checkOutput("abort status latency", obsLat, 2);
    checkOutput("abort status err_cnt", obsRd, 32'h0);

    // Request held high: one ack per accepted request, back-to-back every four cycles.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00000014;
    ackCnt = 0;
    ackMask = '0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        ackCnt++;
        ackMask[n] = 1'b1;
      end
      if (n == 11) cpu_req = 1'b0;
    end
    checkOutput("held req ack count", ackCnt, 3);
    checkOutput("held req ack cycles", ackMask, 32'h00000888);
    checkOutput("held req rdata", cpu_rdata, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
